mem_arbiter: RTL

//  Shares one single-port-per-direction word memory (1-cycle registered read, word-only write) between

---
 rtl/mem_arbiter_pkg.sv | 63 ++++++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and lane helpers for the fetch/LSU memory arbiter.
// Covers access sizes, FSM states, the round-robin owner, alignment checks, load extraction and store merging.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } requester_t;

  // Size encoding 3 is never a legal access, so it reports as misaligned.
  function automatic logic misaligned(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = offset[0];
      SZ_W:    misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  offset,
                                               input logic [1:0]  size,
                                               input logic        unsigned_ld);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      SZ_B:    extract_load = unsigned_ld ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    extract_load = unsigned_ld ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default: extract_load = shifted;
    endcase
  endfunction

  // Replace the addressed byte (B) or halfword (H) lanes of old_word with the right-aligned store data.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [15:0] wdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (size == SZ_B && offset == 2'(i)) begin
        merged[8*i +: 8] = wdata[7:0];
      end else if (size == SZ_H && offset[1] == (i >= 2)) begin
        merged[8*i +: 8] = wdata[8*(i%2) +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the fetch/LSU memory arbiter.
// The slave modport is the arbiter; master is the surrounding core plus the memory block.
interface mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  logic        mem_r_en_o;
  logic [31:0] mem_addr_r_o;
  logic [31:0] mem_data_r_i;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_w_o;
  logic [31:0] mem_data_w_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  lsu_req_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output mem_r_en_o, mem_addr_r_o,
    input  mem_data_r_i,
    output mem_wr_en_o, mem_addr_w_o, mem_data_w_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output lsu_req_i, lsu_we_i, lsu_size_i, lsu_unsigned_i, lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  mem_r_en_o, mem_addr_r_o,
    output mem_data_r_i,
    input  mem_wr_en_o, mem_addr_w_o, mem_data_w_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word memory between instruction fetch and the LSU.
// Sub-word stores are done as a read-modify-write across two cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_ROWS = 512
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_ROWS * 4);

  state_t      state_q, state_d;
  requester_t  rr_last_q, rr_last_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        if_err_q, if_err_d;
  logic        lsu_rvalid_q, lsu_rvalid_d;
  logic        lsu_err_q, lsu_err_d;
  logic        lsu_load_q, lsu_load_d;
  logic [1:0]  lsu_off_q, lsu_off_d;
  logic [1:0]  lsu_size_q, lsu_size_d;
  logic        lsu_uns_q, lsu_uns_d;
  logic [29:0] rmw_word_q, rmw_word_d;
  logic [15:0] rmw_wdata_q, rmw_wdata_d;

  logic        pick_if, pick_lsu;
  logic        if_bad, lsu_bad;
  logic        if_gnt, lsu_gnt;
  logic        mem_r_en, mem_wr_en;
  logic [31:0] mem_addr_r, mem_addr_w, mem_data_w;

  assign if_bad  = (bus.if_addr_i[1:0] != 2'b00) || (bus.if_addr_i >= ADDR_LIMIT);
  assign lsu_bad = misaligned(bus.lsu_addr_i[1:0], bus.lsu_size_i) ||
                   (bus.lsu_addr_i >= ADDR_LIMIT);

  // On a conflict the requester that was not granted last time wins.
  assign pick_if  = (state_q == ST_IDLE) && bus.if_req_i &&
                    (!bus.lsu_req_i || rr_last_q == REQ_LSU);
  assign pick_lsu = (state_q == ST_IDLE) && bus.lsu_req_i && !pick_if;

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    if_rvalid_d  = 1'b0;
    if_err_d     = 1'b0;
    lsu_rvalid_d = 1'b0;
    lsu_err_d    = 1'b0;
    lsu_load_d   = 1'b0;
    lsu_off_d    = lsu_off_q;
    lsu_size_d   = lsu_size_q;
    lsu_uns_d    = lsu_uns_q;
    rmw_word_d   = rmw_word_q;
    rmw_wdata_d  = rmw_wdata_q;
    if_gnt       = 1'b0;
    lsu_gnt      = 1'b0;
    mem_r_en     = 1'b0;
    mem_addr_r   = '0;
    mem_wr_en    = 1'b0;
    mem_addr_w   = '0;
    mem_data_w   = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_if) begin
          if_gnt      = 1'b1;
          rr_last_d   = REQ_IF;
          if_rvalid_d = 1'b1;
          if (if_bad) begin
            if_err_d = 1'b1;
          end else begin
            mem_r_en   = 1'b1;
            mem_addr_r = {bus.if_addr_i[31:2], 2'b00};
          end
        end else if (pick_lsu) begin
          lsu_gnt    = 1'b1;
          rr_last_d  = REQ_LSU;
          lsu_off_d  = bus.lsu_addr_i[1:0];
          lsu_size_d = bus.lsu_size_i;
          lsu_uns_d  = bus.lsu_unsigned_i;
          if (lsu_bad) begin
            lsu_rvalid_d = 1'b1;
            lsu_err_d    = 1'b1;
          end else if (!bus.lsu_we_i) begin
            mem_r_en     = 1'b1;
            mem_addr_r   = {bus.lsu_addr_i[31:2], 2'b00};
            lsu_load_d   = 1'b1;
            lsu_rvalid_d = 1'b1;
          end else if (bus.lsu_size_i == SZ_W) begin
            mem_wr_en    = 1'b1;
            mem_addr_w   = {bus.lsu_addr_i[31:2], 2'b00};
            mem_data_w   = bus.lsu_wdata_i;
            lsu_rvalid_d = 1'b1;
          end else begin
            // Fetch the old word now; the merge and write happen next cycle.
            mem_r_en    = 1'b1;
            mem_addr_r  = {bus.lsu_addr_i[31:2], 2'b00};
            rmw_word_d  = bus.lsu_addr_i[31:2];
            rmw_wdata_d = bus.lsu_wdata_i[15:0];
            state_d     = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        mem_wr_en    = 1'b1;
        mem_addr_w   = {rmw_word_q, 2'b00};
        mem_data_w   = merge_lanes(bus.mem_data_r_i, rmw_wdata_q, lsu_off_q, lsu_size_q);
        lsu_rvalid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset must suppress side effects immediately, including an in-flight RMW write.
    if (rst_i) begin
      if_gnt    = 1'b0;
      lsu_gnt   = 1'b0;
      mem_r_en  = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= REQ_LSU;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_load_q   <= 1'b0;
      lsu_off_q    <= 2'b00;
      lsu_size_q   <= 2'b00;
      lsu_uns_q    <= 1'b0;
      rmw_word_q   <= '0;
      rmw_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_load_q   <= lsu_load_d;
      lsu_off_q    <= lsu_off_d;
      lsu_size_q   <= lsu_size_d;
      lsu_uns_q    <= lsu_uns_d;
      rmw_word_q   <= rmw_word_d;
      rmw_wdata_q  <= rmw_wdata_d;
    end
  end

  assign bus.if_gnt_o     = if_gnt;
  assign bus.lsu_gnt_o    = lsu_gnt;
  assign bus.mem_r_en_o   = mem_r_en;
  assign bus.mem_addr_r_o = mem_addr_r;
  assign bus.mem_wr_en_o  = mem_wr_en;
  assign bus.mem_addr_w_o = mem_addr_w;
  assign bus.mem_data_w_o = mem_data_w;

  // Read data comes straight from the registered memory output, gated to zero unless a good read completes.
  assign bus.if_rvalid_o  = if_rvalid_q;
  assign bus.if_err_o     = if_err_q;
  assign bus.if_rdata_o   = (if_rvalid_q && !if_err_q) ? bus.mem_data_r_i : 32'h0;
  assign bus.lsu_rvalid_o = lsu_rvalid_q;
  assign bus.lsu_err_o    = lsu_err_q;
  assign bus.lsu_rdata_o  = lsu_load_q ? extract_load(bus.mem_data_r_i, lsu_off_q, lsu_size_q, lsu_uns_q)
                                       : 32'h0;

endmodule
